// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM encoding,
// requester count, default hold limit and an index-to-one-hot helper.
package rr_arbiter4_pkg;

  localparam int NREQ         = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int CNT_W_DEF    = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] idx2oh(input logic [1:0] idx);
    idx2oh = NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first set bit of mask scanning ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold: grants one owner,
// keeps it while requesting, and rotates after MAX_HOLD contended cycles.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       idle
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic             PREEMPT   = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_d;
  logic [1:0]       id_d;
  logic             busy_d, idle_d;

  logic [3:0] others, pick_mask;
  logic [1:0] pick_ptr, pick_idx;
  logic       pick_found, at_limit;

  // In GRANT the search starts just past the owner, so hand-off is fair
  // regardless of where ptr was left by the last IDLE arbitration.
  assign others    = req & ~gnt;
  assign pick_mask = (state_q == ST_IDLE) ? req : others;
  assign pick_ptr  = (state_q == ST_IDLE) ? ptr_q : gnt_id + 2'd1;
  assign at_limit  = PREEMPT && (hold_q == HOLD_LAST);

  rr_pick4 u_pick (
    .mask  (pick_mask),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    id_d    = gnt_id;
    busy_d  = busy;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = idx2oh(pick_idx);
          id_d    = pick_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // Release and limit-reached collapse into one hand-off path.
        if (!req[gnt_id] || (at_limit && pick_found)) begin
          ptr_d  = gnt_id + 2'd1;
          hold_d = '0;
          if (pick_found) begin
            gnt_d = idx2oh(pick_idx);
            id_d  = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = !busy_d && ~|req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      ptr_q   <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      idle    <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      gnt_id  <= id_d;
      busy    <= busy_d;
      idle    <= idle_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: three instances (MAX_HOLD 8, 0, 4) share
// clock and reset, each driven by its own request vector.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req8 = '0, req0 = '0, req4 = '0;
  logic [3:0] gnt8, gnt0, gnt4;
  logic [1:0] id8, id0, id4;
  logic       busy8, busy0, busy4;
  logic       idle8, idle0, idle4;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .gnt(gnt8), .gnt_id(id8), .busy(busy8), .idle(idle8));
  rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .gnt(gnt0), .gnt_id(id0), .busy(busy0), .idle(idle0));
  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt(gnt4), .gnt_id(id4), .busy(busy4), .idle(idle4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req8 = '0; req0 = '0; req4 = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if ({gnt8, id8, busy8, idle8} !== 8'b0000_00_0_1)
      $display("FAIL reset_dut8 got=%b exp=%b", {gnt8, id8, busy8, idle8}, 8'b0000_00_0_1); else passed++;
    checks++; if ({gnt0, id0, busy0, idle0} !== 8'b0000_00_0_1)
      $display("FAIL reset_dut0 got=%b exp=%b", {gnt0, id0, busy0, idle0}, 8'b0000_00_0_1); else passed++;
    checks++; if ({gnt4, id4, busy4, idle4} !== 8'b0000_00_0_1)
      $display("FAIL reset_dut4 got=%b exp=%b", {gnt4, id4, busy4, idle4}, 8'b0000_00_0_1); else passed++;
  endtask

  task automatic test_single();
    tick();
    req8 = 4'b0100;
    tick();
    checks++; if ({gnt8, id8, busy8, idle8} !== 8'b0100_10_1_0)
      $display("FAIL single_grant got=%b exp=%b", {gnt8, id8, busy8, idle8}, 8'b0100_10_1_0); else passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (gnt8 !== 4'b0100)
        $display("FAIL single_hold got=%b exp=%b", gnt8, 4'b0100); else passed++;
    end
    req8 = 4'b0000;
    tick();
    checks++; if ({gnt8, busy8, idle8} !== 6'b0000_0_1)
      $display("FAIL single_release got=%b exp=%b", {gnt8, busy8, idle8}, 6'b0000_0_1); else passed++;
  endtask

  task automatic test_all_four();
    int seq [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    req8 = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 8; c++) begin
        checks++; if ({gnt8, id8, busy8} !== {4'(1 << seq[s]), 2'(seq[s]), 1'b1})
          $display("FAIL rotate owner=%0d cyc=%0d got gnt=%b id=%0d busy=%b", seq[s], c, gnt8, id8, busy8);
        else passed++;
        tick();
      end
    end
    checks++; if (gnt8 !== 4'b0010)
      $display("FAIL rotate_wrap got=%b exp=%b", gnt8, 4'b0010); else passed++;
    req8 = '0;
    tick();
  endtask

  task automatic test_no_preempt();
    req0 = 4'b0011;
    tick();
    for (int c = 0; c < 100; c++) begin
      checks++; if (gnt0 !== 4'b0001)
        $display("FAIL nopre_hold cyc=%0d got=%b exp=%b", c, gnt0, 4'b0001); else passed++;
      tick();
    end
    req0 = 4'b0010;
    tick();
    checks++; if ({gnt0, id0, busy0} !== 7'b0010_01_1)
      $display("FAIL nopre_release got=%b exp=%b", {gnt0, id0, busy0}, 7'b0010_01_1); else passed++;
    req0 = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    req8 = 4'b0010;
    tick();
    checks++; if (gnt8 !== 4'b0010)
      $display("FAIL b2b_owner1 got=%b exp=%b", gnt8, 4'b0010); else passed++;
    req8 = 4'b0110;
    tick();
    checks++; if (gnt8 !== 4'b0010)
      $display("FAIL b2b_no_steal got=%b exp=%b", gnt8, 4'b0010); else passed++;
    req8 = 4'b0100;
    tick();
    checks++; if ({gnt8, id8, busy8} !== 7'b0100_10_1)
      $display("FAIL b2b_handoff got=%b exp=%b", {gnt8, id8, busy8}, 7'b0100_10_1); else passed++;
    req8 = 4'b1001;
    tick();
    checks++; if ({gnt8, id8, busy8} !== 7'b1000_11_1)
      $display("FAIL b2b_tie got=%b exp=%b", {gnt8, id8, busy8}, 7'b1000_11_1); else passed++;
  endtask

  task automatic test_reset_mid();
    // Owner 3 from the previous task, granted with hold count 0.
    for (int c = 0; c < 5; c++) tick();
    checks++; if (gnt8 !== 4'b1000)
      $display("FAIL rstmid_pre got=%b exp=%b", gnt8, 4'b1000); else passed++;
    rst  = 1'b1;
    req8 = 4'b0000;
    tick();
    checks++; if ({gnt8, id8, busy8, idle8} !== 8'b0000_00_0_1)
      $display("FAIL rstmid_drop got=%b exp=%b", {gnt8, id8, busy8, idle8}, 8'b0000_00_0_1); else passed++;
    rst  = 1'b0;
    req8 = 4'b1111;
    tick();
    checks++; if ({gnt8, id8, busy8} !== 7'b0001_00_1)
      $display("FAIL rstmid_regrant got=%b exp=%b", {gnt8, id8, busy8}, 7'b0001_00_1); else passed++;
    req8 = '0;
    tick();
  endtask

  task automatic test_limit_release();
    req4 = 4'b1011;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++; if (gnt4 !== 4'b0001)
        $display("FAIL limrel_owner0 cyc=%0d got=%b exp=%b", c, gnt4, 4'b0001); else passed++;
      if (c < 3) tick();
    end
    req4 = 4'b1010;
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++; if ({gnt4, id4} !== 6'b0010_01)
        $display("FAIL limrel_owner1 cyc=%0d got=%b exp=%b", c, {gnt4, id4}, 6'b0010_01); else passed++;
      tick();
    end
    checks++; if ({gnt4, id4, busy4} !== 7'b1000_11_1)
      $display("FAIL limrel_next got=%b exp=%b", {gnt4, id4, busy4}, 7'b1000_11_1); else passed++;
    req4 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_no_preempt();
    test_back_to_back();
    test_reset_mid();
    test_limit_release();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
